// File: rtl/wbarb_pkg.sv
// rtl/wbarb_pkg.sv - shared constants and entry type for the write-back arbiter
package wbarb_pkg;

    localparam int NUM_REQ = 2;
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
        logic                 age;
    } wb_entry_t;

endpackage

// File: rtl/wbarb_slot.sv
// rtl/wbarb_slot.sv - one-entry write-back holding slot with valid/ready and age tracking
module wbarb_slot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    input  logic              other_load_i,
    output logic              valid_o,
    output logic              ready_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0] data_o,
    output logic              age_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              age_q, age_d;

    // Ready comes only from registered state and the pop (grant) strobe,
    // so an accept never feeds back into its own readiness.
    assign ready_o = !rst_i && (!valid_q || pop_i);

    // Next state: a load replaces the entry (even while it is popped),
    // a pop without load empties it. A fresh entry is never older than the
    // other slot; a surviving entry becomes older when the other slot refills.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        age_d   = age_q;
        if (load_i) begin
            valid_d = 1'b1;
            rd_d    = rd_i;
            data_d  = data_i;
            age_d   = 1'b0;
        end else begin
            if (pop_i) begin
                valid_d = 1'b0;
            end
            if (other_load_i) begin
                age_d = 1'b1;
            end
        end
    end

    // Slot registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            age_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            age_q   <= age_d;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;
    assign age_o   = age_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU write-back arbiter for the register file write port (optional WBARB_RR_EN)
module regfile_wb_arbiter
    import wbarb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [ADDR_W-1:0]    lsu_rd,
    input  logic [DATA_W-1:0]    lsu_data,
    output logic                 lsu_ready,
    output logic                 WE3,
    output logic [ADDR_W-1:0]    AD3,
    output logic [DATA_W-1:0]    WD3,
    output logic [2**ADDR_W-1:0] pend_mask,
    output logic [CNT_W-1:0]     contend_cnt
);

    localparam int NREG = 2**ADDR_W;

    logic [NUM_REQ-1:0] slot_v;
    logic [NUM_REQ-1:0] slot_age;
    logic [NUM_REQ-1:0] load;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  slot_rd   [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];

    logic               we_q, we_d;
    logic [ADDR_W-1:0]  ad_q, ad_d;
    logic [DATA_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_any;
    logic               lose;

    // Writes to r0 are accepted but dropped before they reach a slot.
    assign load[REQ_ALU] = alu_valid && alu_ready && (alu_rd != '0);
    assign load[REQ_LSU] = lsu_valid && lsu_ready && (lsu_rd != '0);

    wbarb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_alu (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (load[REQ_ALU]),
        .rd_i         (alu_rd),
        .data_i       (alu_data),
        .pop_i        (grant[REQ_ALU]),
        .other_load_i (load[REQ_LSU]),
        .valid_o      (slot_v[REQ_ALU]),
        .ready_o      (alu_ready),
        .rd_o         (slot_rd[REQ_ALU]),
        .data_o       (slot_data[REQ_ALU]),
        .age_o        (slot_age[REQ_ALU])
    );

    wbarb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_lsu (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (load[REQ_LSU]),
        .rd_i         (lsu_rd),
        .data_i       (lsu_data),
        .pop_i        (grant[REQ_LSU]),
        .other_load_i (load[REQ_ALU]),
        .valid_o      (slot_v[REQ_LSU]),
        .ready_o      (lsu_ready),
        .rd_o         (slot_rd[REQ_LSU]),
        .data_o       (slot_data[REQ_LSU]),
        .age_o        (slot_age[REQ_LSU])
    );

`ifdef WBARB_RR_EN
    logic rr_last_q, rr_last_d;

    // Remember the most recent winner so the other side takes the next tie.
    always_comb begin
        rr_last_d = rr_last_q;
        if (grant[REQ_ALU]) begin
            rr_last_d = 1'b0;
        end else if (grant[REQ_LSU]) begin
            rr_last_d = 1'b1;
        end
    end

    // Round-robin pointer register, reset to "ALU won last".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Grant selection: same destination resolves by age (ALU on a tie, so the
    // LSU value lands last); different destinations use the configured policy.
    always_comb begin
        grant = '0;
        if (slot_v[REQ_ALU] && slot_v[REQ_LSU]) begin
            if (slot_rd[REQ_ALU] == slot_rd[REQ_LSU]) begin
                if (slot_age[REQ_LSU]) begin
                    grant[REQ_LSU] = 1'b1;
                end else begin
                    grant[REQ_ALU] = 1'b1;
                end
            end else begin
`ifdef WBARB_RR_EN
                if (rr_last_q) begin
                    grant[REQ_ALU] = 1'b1;
                end else begin
                    grant[REQ_LSU] = 1'b1;
                end
`else
                grant[REQ_LSU] = 1'b1;
`endif
            end
        end else begin
            grant = slot_v;
        end
    end

    assign grant_any = |grant;
    assign lose      = |(slot_v & ~grant);

    // Output stage next state: address/data only move on a grant so they
    // hold their last value while WE3 is low.
    always_comb begin
        we_d = grant_any;
        ad_d = ad_q;
        wd_d = wd_q;
        if (grant[REQ_LSU]) begin
            ad_d = slot_rd[REQ_LSU];
            wd_d = slot_data[REQ_LSU];
        end else if (grant[REQ_ALU]) begin
            ad_d = slot_rd[REQ_ALU];
            wd_d = slot_data[REQ_ALU];
        end
    end

    // Saturating count of cycles in which a valid slot was passed over.
    always_comb begin
        cnt_d = cnt_q;
        if (lose && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output stage and contention counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q  <= 1'b0;
            ad_q  <= '0;
            wd_q  <= '0;
            cnt_q <= '0;
        end else begin
            we_q  <= we_d;
            ad_q  <= ad_d;
            wd_q  <= wd_d;
            cnt_q <= cnt_d;
        end
    end

    // In-flight destinations: both slots plus the write on the port this cycle.
    always_comb begin
        pend_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            if ((slot_v[REQ_ALU] && slot_rd[REQ_ALU] == ADDR_W'(r)) ||
                (slot_v[REQ_LSU] && slot_rd[REQ_LSU] == ADDR_W'(r)) ||
                (we_q && ad_q == ADDR_W'(r))) begin
                pend_mask[r] = 1'b1;
            end
        end
    end

    assign WE3         = we_q;
    assign AD3         = ad_q;
    assign WD3         = wd_q;
    assign contend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    logic                 clk;
    logic                 rst;
    logic                 alu_valid;
    logic [ADDR_W-1:0]    alu_rd;
    logic [DATA_W-1:0]    alu_data;
    logic                 alu_ready;
    logic                 lsu_valid;
    logic [ADDR_W-1:0]    lsu_rd;
    logic [DATA_W-1:0]    lsu_data;
    logic                 lsu_ready;
    logic                 WE3;
    logic [ADDR_W-1:0]    AD3;
    logic [DATA_W-1:0]    WD3;
    logic [2**ADDR_W-1:0] pend_mask;
    logic [CNT_W-1:0]     contend_cnt;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+DATA_W-1:0] wq[$];

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .WE3         (WE3),
        .AD3         (AD3),
        .WD3         (WD3),
        .pend_mask   (pend_mask),
        .contend_cnt (contend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && WE3) wq.push_back({AD3, WD3});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int ai;
        int li;
        int cyc;
        logic a_acc;
        logic l_acc;

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

        // Reset state
        #3;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_we3", WE3, 0);
        chk("rst_ad3", AD3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_cnt", contend_cnt, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_alu_ready", alu_ready, 1);
        chk("post_rst_lsu_ready", lsu_ready, 1);

        // Single ALU write rd=5
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t1_n1_we3", WE3, 0);
        chk("t1_n1_pend", pend_mask, 64'h20);
        @(negedge clk);
        chk("t1_n2_we3", WE3, 1);
        chk("t1_n2_ad3", AD3, 5);
        chk("t1_n2_wd3", WD3, 64'hDEADBEEF);
        chk("t1_n2_pend", pend_mask, 64'h20);
        @(negedge clk);
        chk("t1_n3_we3", WE3, 0);
        chk("t1_n3_pend", pend_mask, 0);
        chk("t1_n3_ad3_hold", AD3, 5);

        // rd=0 is accepted and dropped
        tick();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        @(negedge clk);
        chk("t2_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_we3", WE3, 0);
            chk("t2_pend", pend_mask, 0);
            chk("t2_ready_hold", alu_ready, 1);
        end

        // Simultaneous same-rd accept: ALU first, LSU last
        tick();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h2;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        chk("t3_n1_we3", WE3, 0);
        chk("t3_n1_pend", pend_mask, 64'h8);
        @(negedge clk);
        chk("t3_n2_we3", WE3, 1);
        chk("t3_n2_ad3", AD3, 3);
        chk("t3_n2_wd3", WD3, 1);
        @(negedge clk);
        chk("t3_n3_we3", WE3, 1);
        chk("t3_n3_wd3", WD3, 2);
        @(negedge clk);
        chk("t3_n4_we3", WE3, 0);
        chk("t3_cnt", contend_cnt, 1);

        // Both requesters streaming different rds
        tick();
        do_reset();
        wq.delete();
        ai = 0; li = 0; cyc = 0;
        while ((ai < 2 || li < 8) && cyc < 40) begin
            alu_valid = (ai < 2);
            alu_rd    = (ai == 0) ? 5'd8 : 5'd9;
            alu_data  = 32'hA0 + 32'(ai);
            lsu_valid = (li < 8);
            lsu_rd    = 5'(16 + li);
            lsu_data  = 32'h100 + 32'(li);
            #1;
            a_acc = alu_valid && alu_ready;
            l_acc = lsu_valid && lsu_ready;
            tick();
            if (a_acc) ai++;
            if (l_acc) li++;
            cyc++;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("t4_stream_done", (ai == 2 && li == 8), 1);
        repeat (6) tick();
        chk("t4_nwrites", wq.size(), 10);
`ifndef WBARB_RR_EN
        chk("t4_cnt_ge7", contend_cnt >= 7, 1);
        if (wq.size() == 10) begin
            for (int k = 0; k < 8; k++) begin
                chk("t4_lsu_order", wq[k], {5'(16 + k), 32'h100 + 32'(k)});
            end
            chk("t4_alu_0", wq[8], {5'd8, 32'hA0});
            chk("t4_alu_1", wq[9], {5'd9, 32'hA1});
        end
`endif

        // Asynchronous reset mid-cycle with both slots full and WE3 high
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        chk("t5_n1_we3", WE3, 0);
        @(negedge clk);
        chk("t5_n2_we3", WE3, 1);
        chk("t5_n2_ad3", AD3, 6);
        chk("t5_n2_pend", pend_mask, 64'h50);
        chk("t5_n2_cnt", contend_cnt, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_we3", WE3, 0);
        chk("t5_rst_pend", pend_mask, 0);
        chk("t5_rst_cnt", contend_cnt, 0);
        chk("t5_rst_alu_ready", alu_ready, 0);
        chk("t5_rst_lsu_ready", lsu_ready, 0);
        wq.delete();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("t5_no_write", wq.size(), 0);
        chk("t5_pend_after", pend_mask, 0);

        // Counter saturation with ALU starved by a continuous LSU stream
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h2;
        repeat ((1 << CNT_W) + 3) tick();
        @(negedge clk);
        chk("t6_cnt_sat", contend_cnt, 64'hFFFF);
        tick();
        @(negedge clk);
        chk("t6_cnt_sat_hold", contend_cnt, 64'hFFFF);
        alu_valid = 1'b0; lsu_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter sharing the register file's single write port (WE3/AD3/WD3) between two requesters: ALU write-back (requester 0) and the load/store unit return path (requester 1). Each requester has a one-entry holding slot with a valid/ready handshake. A registered output stage drives the register file. The block also exports a pending-write mask so issue logic can stall on in-flight destinations, and a saturating contention counter.

## Interface
Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- CNT_W, 16, contention counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU write request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU write data.
- alu_ready  out  1  ALU slot can accept.
- lsu_valid  in  1  LSU write request.
- lsu_rd  in  ADDR_W  LSU destination register.
- lsu_data  in  DATA_W  LSU write data.
- lsu_ready  out  1  LSU slot can accept.
- WE3  out  1  register file write enable.
- AD3  out  ADDR_W  register file write address.
- WD3  out  DATA_W  register file write data.
- pend_mask  out  2**ADDR_W  bit r = write to register r in flight.
- contend_cnt  out  CNT_W  cycles a slot waited on a competing grant (saturating).

## Operation
- Accept: a request is accepted on an edge where valid && ready. Requests with rd == 0 are accepted and discarded: no slot fill, no pend bit, no WE3.
- Slot: each requester's slot holds {rd, data, age}. age is 1 if the slot was filled on an earlier edge than the other valid slot.
- ready_i = !slot_v[i] || grant[i]. It depends only on registered state and grant, never on valid_i. A slot therefore sustains one accept per cycle while it keeps winning.
- Grant: at most one slot per cycle moves into the output stage, selected in this order:
  1. Both slots valid and targeting the same rd: the older slot wins. If both were filled on the same edge, ALU wins, so the LSU value lands last.
  2. Both valid, different rd: policy per Configuration.
  3. One valid: it wins.
- Output stage: on every edge it loads WE3 <= grant_any, AD3/WD3 <= granted slot contents. WE3 is high for exactly one cycle per write. AD3 and WD3 hold their last value when WE3 = 0.
- pend_mask: OR over valid slots and the output stage (when WE3 = 1) of onehot(rd). Bit 0 is always 0. The mask is combinational from registered state.
- contend_cnt: increments on each edge where some slot is valid and not granted. It saturates at all-ones and never wraps.

## Timing
- Request accepted at edge N (end of cycle N): the slot is valid in cycle N+1 and granted at the earliest at edge N+1. WE3 is high in cycle N+2, and the register file captures the write at edge N+2.
- Minimum latency from accept to WE3 is 2 cycles. Throughput is one write per cycle total. A losing slot waits one extra cycle per lost grant.
- Reset (async assert, any time): slots invalid, WE3 = 0, AD3 = 0, WD3 = 0, pend_mask = 0, contend_cnt = 0, RR pointer = ALU. alu_ready = lsu_ready = 1 once rst is deasserted; during reset both are 0.
- Reset mid-operation drops all in-flight writes; no partial write is emitted.
- A new accept on an edge where the same slot is granted: the old contents move to the output stage and the new contents load into the slot on the same edge.

## Configuration
- WBARB_RR_EN defined: round-robin between different-rd slots. A 1-bit pointer records the last winner, and the other requester wins the next tie. Worst-case wait is 1 cycle.
- WBARB_RR_EN undefined: fixed priority, LSU wins every different-rd tie and there is no pointer register. The ALU may starve while the LSU streams; contend_cnt exposes this.
- The same-rd age rule applies in both modes.

## Structure
- Package wbarb_pkg holds:
  - constants NUM_REQ = 2, REQ_ALU = 0, REQ_LSU = 1;
  - typedef wb_entry_t {logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; logic age;} at default widths.
- Sub-module wbarb_slot: one-entry holding register with valid/ready, load, pop and age tracking. It is instantiated once per requester.
- The top level contains grant logic, the output stage, pend_mask and contend_cnt.

## Test plan
- Single ALU write rd=5, data=0xDEADBEEF at edge N: WE3 = 1, AD3 = 5, WD3 = 0xDEADBEEF in cycle N+2 only; pend_mask[5] = 1 in cycles N+1..N+2, then 0.
- ALU rd=0, data=0x1234: alu_ready stays 1, WE3 never asserts, pend_mask stays 0.
- Simultaneous accept, ALU rd=3 = 0x1 and LSU rd=3 = 0x2: WE3 writes 0x1 and then 0x2 on consecutive cycles; contend_cnt = 1.
- Both requesters streaming different rds for 8 cycles:
  - with WBARB_RR_EN, grants alternate ALU/LSU and neither ready stays low more than 1 cycle;
  - without it, all LSU writes precede ALU writes and contend_cnt ≥ 7.
- rst asserted asynchronously mid-cycle with both slots full and WE3 = 1: WE3, pend_mask and contend_cnt go to 0 immediately, with no write after rst is released.
- Hold a slot losing for 2**CNT_W + 3 cycles: contend_cnt sticks at all-ones.
